// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared ALU control encodings for the ALU control decoder and the execute stage
package mips_alu_pkg;
    // 3-bit ALU operation codes produced by the ALU control decoder
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    // R-type funct-field values the decoder maps onto the codes above
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU, (alu_func, a, b) -> (result, zero[, ovf])
// Ports: alu_func op code, a/b operands, result, zero (result == 0),
// ovf signed overflow (present only when ALU_OVF_EN is defined).
module alu_core
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;
    assign w_sum  = a + b;
    assign w_diff = a - b;
    // Exact signed compare; the sign of a-b is wrong when the subtraction overflows
    assign w_slt  = $signed(a) < $signed(b);
    always_comb begin
        result = alu_func == ALU_ADD ? w_sum :
                 alu_func == ALU_SUB ? w_diff :
                 alu_func == ALU_AND ? (a & b) :
                 alu_func == ALU_OR  ? (a | b) :
                 alu_func == ALU_SLT ? {{(WIDTH-1){1'b0}}, w_slt} :
                 '0;
        zero = result == '0;
    end
`ifdef ALU_OVF_EN
    always_comb begin
        ovf = alu_func == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]) :
              alu_func == ALU_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]) :
              1'b0;
    end
`endif
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage applying the ALU op code and registering the result toward EX/MEM
// Ports: clk, rst (sync, active-high); in_valid/in_ready/alu_func/a/b upstream handshake;
// flush discards all work; out_valid/out_ready/result/zero downstream handshake;
// ovf exists only when ALU_OVF_EN is defined.
// Storage is an output register plus a one-entry skid register so a downstream stall
// never drops a result that was accepted while in_ready was still high.
module alu_exec_stage
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_acc;
    logic             w_oload;
    logic             r_ov;
    logic [WIDTH-1:0] r_ores;
    logic             r_ozero;
    logic             r_sv;
    logic [WIDTH-1:0] r_sres;
    logic             r_szero;
`ifdef ALU_OVF_EN
    logic             w_ovf;
    logic             r_oovf;
    logic             r_sovf;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_func (alu_func),
        .a        (a),
        .b        (b),
        .result   (w_res),
        .zero     (w_zero)
`ifdef ALU_OVF_EN
        ,
        .ovf      (w_ovf)
`endif
    );

    // Ready comes straight from the skid flag, so it never depends on out_ready combinationally
    assign in_ready = !r_sv;
    assign w_acc    = in_valid && in_ready;
    assign w_oload  = !r_ov || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov    <= 1'b0;
            r_sv    <= 1'b0;
            r_ores  <= '0;
            r_ozero <= 1'b0;
            r_sres  <= '0;
            r_szero <= 1'b0;
`ifdef ALU_OVF_EN
            r_oovf  <= 1'b0;
            r_sovf  <= 1'b0;
`endif
        end else if (flush) begin
            r_ov <= 1'b0;
            r_sv <= 1'b0;
        end else if (w_oload) begin
            // The skid entry is older than any new input, so it drains first;
            // with the skid full in_ready is low and no input competes for OREG
            r_ov <= r_sv || w_acc;
            r_sv <= 1'b0;
            if (r_sv) begin
                r_ores  <= r_sres;
                r_ozero <= r_szero;
`ifdef ALU_OVF_EN
                r_oovf  <= r_sovf;
`endif
            end else if (w_acc) begin
                r_ores  <= w_res;
                r_ozero <= w_zero;
`ifdef ALU_OVF_EN
                r_oovf  <= w_ovf;
`endif
            end
        end else if (w_acc) begin
            r_sv    <= 1'b1;
            r_sres  <= w_res;
            r_szero <= w_zero;
`ifdef ALU_OVF_EN
            r_sovf  <= w_ovf;
`endif
        end
    end

    assign out_valid = r_ov;
    assign result    = r_ores;
    assign zero      = r_ozero;
`ifdef ALU_OVF_EN
    assign ovf       = r_oovf;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench for alu_exec_stage (ovf checks when ALU_OVF_EN is defined)
module tb_alu_exec_stage;
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_func = 3'b011;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_func  (alu_func),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
`ifdef ALU_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic signed [32:0] s;
        e = '0;
        case (f)
            3'b010: begin
                s = $signed({x[31], x}) + $signed({y[31], y});
                e.r = s[31:0];
                e.o = s[32] != s[31];
            end
            3'b110: begin
                s = $signed({x[31], x}) - $signed({y[31], y});
                e.r = s[31:0];
                e.o = s[32] != s[31];
            end
            3'b000: e.r = x & y;
            3'b001: e.r = x | y;
            3'b111: e.r = {31'd0, $signed(x) < $signed(y)};
            default: e.r = '0;
        endcase
`ifndef ALU_OVF_EN
        e.o = 1'b0;
`endif
        e.z = e.r == 32'd0;
        return e;
    endfunction

    // Scoreboard: every downstream transfer pops the oldest expected entry
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            n_total++;
            if (q.size() == 0) begin
                $display("FAIL sb_unexpected: got result=%h with no entry expected", result);
            end else begin
                exp_t e;
                logic ok;
                e = q.pop_front();
                ok = result === e.r && zero === e.z;
`ifdef ALU_OVF_EN
                ok = ok && ovf === e.o;
                if (!ok) $display("FAIL sb_result: got r=%h z=%b o=%b want r=%h z=%b o=%b", result, zero, ovf, e.r, e.z, e.o);
`else
                if (!ok) $display("FAIL sb_result: got r=%h z=%b want r=%h z=%b", result, zero, e.r, e.z);
`endif
                if (ok) n_pass++;
            end
        end
    end

    // Drives one op at posedge+1 and returns at posedge+1 after the accepting edge
    task automatic send(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic ok;
        int   t;
        alu_func = f;
        a = x;
        b = y;
        in_valid = 1'b1;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) q.push_back(model(f, x, y));
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, t);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_total++;
        if (q.size() != 0) $display("FAIL drain: %0d entries left, want 0", q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_total += 4;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        if (result !== 32'd0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
        if (zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
`ifdef ALU_OVF_EN
        n_total++;
        if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
`endif
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(3'b010, 32'd7, 32'd5);
        n_total += 3;
        if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid); else n_pass++;
        if (result !== 32'd12) $display("FAIL add_result: got %h want 0000000c", result); else n_pass++;
        if (zero !== 1'b0) $display("FAIL add_zero: got %b want 0", zero); else n_pass++;
        drain();
    endtask

    task automatic test_slt();
        out_ready = 1'b1;
        send(3'b111, 32'hFFFF_FFFF, 32'd1);
        n_total++;
        if (result !== 32'd1) $display("FAIL slt_neg: got %h want 1", result); else n_pass++;
        send(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
        n_total++;
        if (result !== 32'd0) $display("FAIL slt_ovf_case: got %h want 0", result); else n_pass++;
        drain();
    endtask

    task automatic test_sub_nop();
        out_ready = 1'b1;
        send(3'b110, 32'd9, 32'd9);
        n_total += 2;
        if (result !== 32'd0) $display("FAIL sub_result: got %h want 0", result); else n_pass++;
        if (zero !== 1'b1) $display("FAIL sub_zero: got %b want 1", zero); else n_pass++;
        send(3'b011, 32'd3, 32'd4);
        n_total += 2;
        if (result !== 32'd0) $display("FAIL nop_result: got %h want 0", result); else n_pass++;
        if (zero !== 1'b1) $display("FAIL nop_zero: got %b want 1", zero); else n_pass++;
        send(3'b101, 32'd3, 32'd4);
        n_total++;
        if (zero !== 1'b1 || out_valid !== 1'b1) $display("FAIL undef_op: got z=%b v=%b want 1 1", zero, out_valid); else n_pass++;
        drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(3'b010, 32'd1, 32'd1);
        send(3'b001, 32'd4, 32'd1);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else n_pass++;
        alu_func = 3'b000;
        a = 32'd6;
        b = 32'd3;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total += 2;
            if (in_ready !== 1'b0) $display("FAIL stall_hold_ready: got %b want 0", in_ready); else n_pass++;
            if (out_valid !== 1'b1 || result !== 32'd2) $display("FAIL stall_hold_out: got v=%b r=%h want 1 2", out_valid, result); else n_pass++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'b000, 32'd6, 32'd3);
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(3'b010, 32'd10, 32'd1);
        send(3'b010, 32'd20, 32'd1);
        alu_func = 3'b001;
        a = 32'h55;
        b = 32'h0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        q.delete();
        n_total += 2;
        if (out_valid !== 1'b0) $display("FAIL flush_full_valid: got %b want 0", out_valid); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL flush_full_ready: got %b want 1", in_ready); else n_pass++;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL flush_ghost: got out_valid=%b want 0", out_valid); else n_pass++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(3'b010, 32'd30, 32'd1);
        alu_func = 3'b010;
        a = 32'd40;
        b = 32'd1;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        q.delete();
        n_total += 2;
        if (out_valid !== 1'b0) $display("FAIL flush_accept_valid: got %b want 0", out_valid); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL flush_accept_ready: got %b want 1", in_ready); else n_pass++;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(3'b001, 32'hF0, 32'h0F);
        drain();
    endtask

`ifdef ALU_OVF_EN
    task automatic test_ovf();
        out_ready = 1'b1;
        send(3'b010, 32'h7FFF_FFFF, 32'd1);
        n_total += 2;
        if (ovf !== 1'b1) $display("FAIL ovf_add: got %b want 1", ovf); else n_pass++;
        if (result !== 32'h8000_0000) $display("FAIL ovf_add_result: got %h want 80000000", result); else n_pass++;
        send(3'b110, 32'h8000_0000, 32'd1);
        n_total++;
        if (ovf !== 1'b1) $display("FAIL ovf_sub: got %b want 1", ovf); else n_pass++;
        send(3'b000, 32'h8000_0000, 32'd1);
        n_total++;
        if (ovf !== 1'b0) $display("FAIL ovf_and: got %b want 0", ovf); else n_pass++;
        drain();
    endtask
`endif

    task automatic test_back_to_back();
        int   sent;
        logic acc;
        logic [31:0] edges [4];
        edges[0] = 32'h0;
        edges[1] = 32'h7FFF_FFFF;
        edges[2] = 32'h8000_0000;
        edges[3] = 32'hFFFF_FFFF;
        sent = 0;
        for (int c = 0; c < 800 && sent < 60; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                alu_func = 3'($urandom_range(0, 7));
                a = $urandom_range(0, 1) != 0 ? $urandom : edges[$urandom_range(0, 3)];
                b = $urandom_range(0, 1) != 0 ? $urandom : edges[$urandom_range(0, 3)];
                in_valid = 1'b1;
            end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(alu_func, a, b));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_total++;
        if (sent != 60) $display("FAIL b2b_sent: got %0d accepted want 60", sent); else n_pass++;
        drain();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_slt();
        test_sub_nop();
        test_stall();
        test_flush();
`ifdef ALU_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
